adpcm_uart_tx: RTL and testbench
================================

ADPCM_UART_TX -- requirements
Module: adpcm_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per UART bit (legal range 2..65535).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, byte FIFO depth (power of two, 2..64).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit, in_code is valid this cycle (the ADPCM encoder outValid).
REQ-006 The block SHALL have port in_code, input, 4 bits, ADPCM code nibble (the ADPCM encoder encPcm).
REQ-007 The block SHALL have port flush, input, 1 bit, force out a pending half byte.
REQ-008 The block SHALL have port clr_ovf, input, 1 bit, clears the overflow flag.
REQ-009 The block SHALL have port tx, output, 1 bit, UART serial line, idle high.
REQ-010 The block SHALL have port busy, output, 1 bit, high while a frame is on tx or the FIFO is non-empty.
REQ-011 The block SHALL have port overflow, output, 1 bit, sticky dropped-byte flag.

Function
REQ-012 Packer: the first nibble accepted SHALL go to byte[3:0] and the second to byte[7:4]; the completed byte SHALL be pushed on the edge that captures the second nibble.
REQ-013 Flush with a half byte pending SHALL push {4'h0, pending nibble}; flush with nothing pending SHALL do nothing.
REQ-014 in_valid and flush in the same cycle SHALL capture the nibble first and then apply flush; if that nibble completes a byte, flush SHALL have no extra effect.
REQ-015 FIFO: first in, first out, FIFO_DEPTH bytes; a push and a pop in the same cycle SHALL both take effect, including when the FIFO is full.
REQ-016 A push to a full FIFO with no simultaneous pop SHALL drop the byte and set overflow; FIFO contents SHALL be unchanged.
REQ-017 overflow SHALL hold until clr_ovf=1; if clr_ovf and a new overflow occur in the same cycle, overflow SHALL remain 1.
REQ-018 TX state machine states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-019 IDLE -> START when the FIFO is non-empty, popping one byte; START -> DATA; DATA -> PARITY after bit 7 (or -> STOP when parity is compiled out); PARITY -> STOP; STOP -> IDLE, or -> START directly with a pop if the FIFO is non-empty.
REQ-020 Each bit SHALL last exactly CLKS_PER_BIT cycles: start=0, data LSB first, stop=1.
REQ-021 Latency: a byte pushed at edge N into an empty FIFO with TX idle SHALL drive tx low from edge N+1.
REQ-022 Back-to-back frames SHALL have no idle gap between a stop bit and the next start bit.
REQ-023 The bit counter SHALL be sized for CLKS_PER_BIT-1 and SHALL wrap to 0 at each bit boundary.
REQ-024 busy SHALL equal (state != IDLE) OR (FIFO not empty).

Reset
REQ-025 While rst_n=0 the block SHALL hold tx=1, busy=0 and overflow=0, with the FIFO empty, no pending nibble and the state IDLE.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately, so that tx goes high asynchronously; no partial byte SHALL be resent after release.
REQ-027 After rst_n deasserts, the first accepted nibble SHALL be treated as a low nibble.

Configuration
REQ-028 With macro ADPCM_UART_PARITY_EN defined, the block SHALL insert an even-parity bit (XOR of the 8 data bits) between data and stop, giving an 11-bit frame.
REQ-029 Without ADPCM_UART_PARITY_EN, the PARITY state and its logic SHALL be absent and the frame SHALL be 10 bits.

Verification (bench CLKS_PER_BIT=4, FIFO_DEPTH=8)
REQ-030 Codes 0x3 then 0xA -> one frame with byte 0xA3: tx low 4 cycles starting 1 cycle after the second capture, then 1,1,0,0,0,1,0,1 and stop; with parity, parity=0.
REQ-031 Code 0x5 then flush -> byte 0x05 sent; a second flush with nothing pending -> no frame.
REQ-032 20 nibbles (10 bytes) in consecutive cycles -> 9 bytes sent in order, the last-pushed byte dropped, overflow=1; clr_ovf -> overflow=0.
REQ-033 Three bytes queued -> three contiguous frames, stop bit immediately followed by start bit, busy high throughout, busy low 1 cycle after the final stop bit.
REQ-034 rst_n pulsed low during data bit 3 -> tx=1 immediately, busy=0, FIFO empty; the next two nibbles 0x1, 0x2 -> byte 0x21.
REQ-035 in_valid=1 with code 0x7 and flush=1 in the same cycle, nothing pending -> byte 0x07 sent.

Source files
------------

// File: rtl/adpcm_uart_tx.sv
// -----------------------------------------------------------------------------
// adpcm_uart_tx
//
// Packs 4-bit ADPCM codes into bytes (first nibble -> byte[3:0], second ->
// byte[7:4]), queues them in a small byte FIFO and serialises each byte as an
// 8N1 UART frame (start=0, data LSB first, stop=1) at CLKS_PER_BIT clocks per
// bit. Back-to-back bytes go out with no idle gap between frames.
//
// Optional feature: define ADPCM_UART_PARITY_EN to insert an even-parity bit
// (XOR of the 8 data bits) between the last data bit and the stop bit.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (2..65535)
//   FIFO_DEPTH    byte FIFO depth (power of two, 2..64)
//
// Ports:
//   clk       single clock
//   rst_n     asynchronous active-low reset
//   in_valid  in_code is valid this cycle
//   in_code   ADPCM code nibble
//   flush     push out a pending half byte as {4'h0, nibble}
//   clr_ovf   clear the sticky overflow flag
//   tx        UART serial line, idle high
//   busy      frame on tx or FIFO non-empty
//   overflow  sticky: a completed byte was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module adpcm_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in_code,
  input  logic       flush,
  input  logic       clr_ovf,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef ADPCM_UART_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  // ---------------------------------------------------------------------------
  // Nibble packer
  // ---------------------------------------------------------------------------
  logic       pend_valid_q, pend_valid_d;
  logic [3:0] pend_nib_q,   pend_nib_d;
  logic       push;
  logic [7:0] push_byte;

  // NOTE: every signal assigned in an always_comb gets a default at the top so
  // no path leaves it unassigned, which would infer a latch.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_nib_d   = pend_nib_q;
    push         = 1'b0;
    push_byte    = 8'h00;
    if (in_valid) begin
      if (pend_valid_q) begin
        push         = 1'b1;
        push_byte    = {in_code, pend_nib_q};
        pend_valid_d = 1'b0;
      end else begin
        pend_valid_d = 1'b1;
        pend_nib_d   = in_code;
      end
    end
    // Flush looks at the state after this cycle's capture: a nibble that just
    // completed a byte leaves nothing pending, so flush is then a no-op.
    if (flush && pend_valid_d) begin
      push         = 1'b1;
      push_byte    = {4'h0, pend_nib_d};
      pend_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Byte FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          overflow_q, overflow_d;
  logic          pop;
  logic          wr_en;
  logic          fifo_empty;
  logic          fifo_full;
  logic [7:0]    fifo_rdata;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_rdata = mem[rd_ptr_q];

  always_comb begin
    // A full FIFO still accepts a push when the transmitter pops in the same
    // cycle; only an unmatched push to a full FIFO is dropped.
    wr_en      = push && (!fifo_full || pop);
    wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A new drop wins over a same-cycle clear.
    overflow_d = (overflow_q && !clr_ovf) || (push && fifo_full && !pop);
  end

  // NOTE: the storage array has no reset; emptiness is defined by the
  // pointers and count alone, which keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= push_byte;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit state machine
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [2:0]    bit_q,   bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          bit_end;

  assign bit_end = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    // The bit counter free-runs inside a frame and wraps at every bit boundary.
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_d   = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
`ifdef ADPCM_UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef ADPCM_UART_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          // Chain straight into the next start bit so frames stay contiguous.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rdata;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is decoded straight from registered state, so reset forces it high
  // without waiting for a clock edge.
  always_comb begin
    tx = 1'b1;
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = shift_q[bit_q];
`ifdef ADPCM_UART_PARITY_EN
      PARITY:  tx = ^shift_q;
`endif
      default: tx = 1'b1;
    endcase
  end

  assign busy     = (state_q != IDLE) || !fifo_empty;
  assign overflow = overflow_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values computed before this edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_q <= 1'b0;
      pend_nib_q   <= 4'h0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= 3'd0;
      shift_q      <= 8'h00;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_nib_q   <= pend_nib_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
    end
  end

endmodule

// File: tb/tb_adpcm_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_adpcm_uart_tx
//
// Self-checking bench for adpcm_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=8).
// The reference model works at the frame level: each accepted byte is given a
// start time (max(push+1, end of previous frame)); the FIFO occupancy at a
// push is the number of accepted bytes not yet started. From that schedule the
// bench derives the expected tx level, busy and overflow for every cycle. A
// small UART receiver decodes tx into bytes for end-to-end comparison.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_adpcm_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
`ifdef ADPCM_UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int L = FB * CPB;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_code;
  logic       flush;
  logic       clr_ovf;
  logic       tx;
  logic       busy;
  logic       overflow;

  adpcm_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_code  (in_code),
    .flush    (flush),
    .clr_ovf  (clr_ovf),
    .tx       (tx),
    .busy     (busy),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    int         push_e;
    int         start_e;
    logic [7:0] data;
  } frame_t;

  frame_t     fq[$];
  logic [7:0] exp_bytes[$];
  bit         pend_m;
  logic [3:0] pnib_m;
  bit         ovf_m;

  function automatic logic frame_bit(logic [7:0] d, int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
`ifdef ADPCM_UART_PARITY_EN
    if (k == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  function automatic logic exp_tx(int t);
    foreach (fq[i]) begin
      if (t >= fq[i].start_e && t < fq[i].start_e + L)
        return frame_bit(fq[i].data, (t - fq[i].start_e) / CPB);
    end
    return 1'b1;
  endfunction

  function automatic logic exp_busy(int t);
    foreach (fq[i]) begin
      if (t >= fq[i].push_e && t < fq[i].start_e + L) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void model_push(int e, logic [7:0] b);
    int     in_fifo  = 0;
    bit     pop_now  = 0;
    int     last_end = 0;
    int     s;
    frame_t f;
    foreach (fq[i]) begin
      if (fq[i].push_e < e && fq[i].start_e >= e) in_fifo++;
      if (fq[i].start_e == e) pop_now = 1;
      if (fq[i].start_e + L > last_end) last_end = fq[i].start_e + L;
    end
    if (in_fifo >= DEPTH && !pop_now) begin
      ovf_m = 1;
      return;
    end
    s = (e + 1 > last_end) ? e + 1 : last_end;
    f.push_e = e; f.start_e = s; f.data = b;
    fq.push_back(f);
    exp_bytes.push_back(b);
  endfunction

  function automatic bit model_idle();
    foreach (fq[i]) begin
      if (fq[i].start_e + L > cyc) return 0;
    end
    return 1;
  endfunction

  function automatic void model_reset();
    fq.delete();
    pend_m = 0;
    pnib_m = 4'h0;
    ovf_m  = 0;
  endfunction

  // Drive one cycle of inputs, then apply the spec's packing/FIFO rules for
  // the edge that captured them.
  task automatic step(input logic v, input logic [3:0] c, input logic fl, input logic clr);
    int e;
    in_valid = v; in_code = c; flush = fl; clr_ovf = clr;
    @(posedge clk);
    #1;
    if (rst_n) begin
      e = cyc;
      if (clr) ovf_m = 0;
      if (v) begin
        if (pend_m) begin
          model_push(e, {c, pnib_m});
          pend_m = 0;
        end else begin
          pend_m = 1;
          pnib_m = c;
        end
      end
      if (fl && pend_m) begin
        model_push(e, {4'h0, pnib_m});
        pend_m = 0;
      end
      while (fq.size() > 0 && fq[0].start_e + L < cyc - 1) void'(fq.pop_front());
    end
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 3000; i++) begin
      if (model_idle()) break;
      step(0, 4'h0, 0, 0);
    end
    if (i == 3000) check("idle_timeout", 32'd0, 32'd1);
    step(0, 4'h0, 0, 0);
    step(0, 4'h0, 0, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Per-cycle comparison and UART receiver
  // ---------------------------------------------------------------------------
  bit         mon_en = 0;
  bit         rx_active = 0;
  int         rx_t = 0;
  logic [7:0] rx_byte;
  logic [7:0] rx_q[$];
  int         rx_start_q[$];

  always @(negedge clk) begin
    if (mon_en) begin
      check("tx", tx, exp_tx(cyc));
      check("busy", busy, exp_busy(cyc));
      check("overflow", overflow, ovf_m);
      if (!rst_n) begin
        rx_active = 0;
      end else if (!rx_active) begin
        if (tx == 1'b0) begin
          rx_active = 1;
          rx_t      = 0;
          rx_start_q.push_back(cyc);
        end
      end else begin
        rx_t++;
        if (rx_t % CPB == CPB / 2) begin
          int k;
          k = rx_t / CPB;
          if (k == 0) check("rx_start", tx, 1'b0);
          else if (k <= 8) rx_byte[k-1] = tx;
`ifdef ADPCM_UART_PARITY_EN
          else if (k == 9) check("rx_parity", tx, ^rx_byte);
`endif
          else check("rx_stop", tx, 1'b1);
        end
        if (rx_t == L - 1) begin
          rx_q.push_back(rx_byte);
          rx_active = 0;
        end
      end
    end
  end

  task automatic clear_rx();
    rx_q.delete();
    rx_start_q.delete();
    exp_bytes.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [3:0] codes[20];
  int         s0;

  initial begin
    rst_n = 0; in_valid = 0; in_code = 4'h0; flush = 0; clr_ovf = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1;
    step(0, 4'h0, 0, 0);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    rst_n = 1;
    step(0, 4'h0, 0, 0);

    // 0x3 then 0xA -> 0xA3, start bit one cycle after the second capture.
    clear_rx();
    step(1, 4'h3, 0, 0);
    step(1, 4'hA, 0, 0);
    check("lat_before_pop", tx, 1'b1);
    step(0, 4'h0, 0, 0);
    check("lat_start_bit", tx, 1'b0);
    wait_idle();
    check("a3_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("a3_byte", rx_q[0], 8'hA3);

    // 0x5 then flush -> 0x05; second flush with nothing pending -> nothing.
    clear_rx();
    step(1, 4'h5, 0, 0);
    step(0, 4'h0, 1, 0);
    wait_idle();
    step(0, 4'h0, 1, 0);
    repeat (2 * L) step(0, 4'h0, 0, 0);
    check("flush_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("flush_byte", rx_q[0], 8'h05);

    // valid + flush together with nothing pending -> 0x07.
    clear_rx();
    step(1, 4'h7, 1, 0);
    wait_idle();
    check("vflush_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("vflush_byte", rx_q[0], 8'h07);

    // 20 nibbles back to back: 10 bytes, 9 sent, last dropped.
    clear_rx();
    foreach (codes[i]) codes[i] = 4'($urandom);
    foreach (codes[i]) step(1, codes[i], 0, 0);
    check("ovf_set", overflow, 1'b1);
    wait_idle();
    check("ovf_count", rx_q.size(), 9);
    for (int i = 0; i < 9 && i < rx_q.size(); i++)
      check("ovf_order", rx_q[i], {codes[2*i+1], codes[2*i]});
    check("ovf_held", overflow, 1'b1);
    step(0, 4'h0, 0, 1);
    check("ovf_cleared", overflow, 1'b0);

    // Three bytes queued -> contiguous frames.
    clear_rx();
    for (int i = 0; i < 6; i++) step(1, 4'($urandom), 0, 0);
    wait_idle();
    check("b2b_count", rx_q.size(), 3);
    for (int i = 1; i < 3 && i < rx_start_q.size(); i++)
      check("b2b_gap", rx_start_q[i] - rx_start_q[i-1], L);

    // Reset during data bit 3 with a byte queued and a nibble pending.
    clear_rx();
    step(1, 4'h3, 0, 0);
    step(1, 4'hC, 0, 0);
    s0 = (fq.size() > 0) ? fq[fq.size()-1].start_e : cyc;
    step(1, 4'h9, 0, 0);
    step(1, 4'h6, 0, 0);
    step(1, 4'hE, 0, 0);
    for (int i = 0; i < 200 && cyc < s0 + 17; i++) step(0, 4'h0, 0, 0);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    check("rst_mid_tx", tx, 1'b1);
    check("rst_mid_busy", busy, 1'b0);
    step(0, 4'h0, 0, 0);
    step(0, 4'h0, 0, 0);
    rst_n = 1;
    repeat (2 * L) step(0, 4'h0, 0, 0);
    check("rst_no_resend", rx_q.size(), 0);
    clear_rx();
    step(1, 4'h1, 0, 0);
    step(1, 4'h2, 0, 0);
    wait_idle();
    check("rst_after_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("rst_after_byte", rx_q[0], 8'h21);

    // Randomised bursts checked against the frame-schedule model.
    for (int b = 0; b < 30; b++) begin
      int nb;
      clear_rx();
      nb = $urandom_range(1, 24);
      for (int i = 0; i < nb; i++)
        step(($urandom_range(0, 3) != 0), 4'($urandom),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
      step(0, 4'h0, 1, 0);
      wait_idle();
      check("rand_count", rx_q.size(), exp_bytes.size());
      for (int i = 0; i < rx_q.size() && i < exp_bytes.size(); i++)
        check("rand_byte", rx_q[i], exp_bytes[i]);
      step(0, 4'h0, 0, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
